// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: run control, PC address, program-load port and the
// registered instruction/status outputs.
interface instr_fetch_if #(
  parameter int IW  = 9,
  parameter int PCW = 10
);
  logic            Start;
  logic [PCW-1:0]  prog_ctr;
  logic            flush;
  logic            load_en;
  logic [PCW-1:0]  load_addr;
  logic [IW-1:0]   load_data;
  logic [IW-1:0]   instr;
  logic            instr_valid;
  logic            done;
  logic [15:0]     inst_count;

  modport master (
    output Start, prog_ctr, flush, load_en, load_addr, load_data,
    input  instr, instr_valid, done, inst_count
  );

  modport slave (
    input  Start, prog_ctr, flush, load_en, load_addr, load_data,
    output instr, instr_valid, done, inst_count
  );
endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction-fetch register: synchronous read of a loadable program memory,
// branch squash, halt detection and saturating retired-instruction count.
module instr_fetch_reg #(
  parameter int            IW        = 9,
  parameter int            PCW       = 10,
  parameter logic [IW-1:0] HALT_WORD = 9'h1FF
) (
  input  logic          clk,
  input  logic          Reset,
  instr_fetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   mem [2**PCW];
  logic [IW-1:0]   instr_p1;
  logic            vld_p1;
  logic            done_p1;
  logic [15:0]     count_p1;
  logic            halt_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Halt and retirement act on the word currently presented to decode.
  assign halt_hit = vld_p1 && (instr_p1 == HALT_WORD);

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.Start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     if (halt_hit) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Program memory is not reset so a loaded program survives Reset.
  always_ff @(posedge clk) begin
    if (!Reset && state == IDLE && bus.load_en)
      mem[bus.load_addr] <= bus.load_data;
  end

  // Stage p1: registered instruction word, valid, done and count.
  always_ff @(posedge clk) begin
    if (Reset) begin
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      count_p1 <= '0;
    end else if (bus.Start) begin
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1   <= 1'b0;
          count_p1 <= '0;
        end
        RUN: begin
          instr_p1 <= mem[bus.prog_ctr];
          vld_p1   <= ~bus.flush;
          if (vld_p1) count_p1 <= sat_inc(count_p1);
          if (halt_hit) begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.instr       = instr_p1;
  assign bus.instr_valid = vld_p1;
  assign bus.done        = done_p1;
  assign bus.inst_count  = count_p1;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Bench for instr_fetch_reg: directed vector table, hand sequences for load,
// reset and saturation, then random stimulus against a behavioural model.
module tb_instr_fetch_reg;
  localparam int         IW   = 9;
  localparam int         PCW  = 10;
  localparam logic [8:0] HALT = 9'h1FF;

  logic clk = 1'b0;
  logic Reset;

  instr_fetch_if #(.IW(IW), .PCW(PCW)) bus ();

  instr_fetch_reg #(.IW(IW), .PCW(PCW), .HALT_WORD(HALT)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Behavioural reference: phase 0 = waiting, 1 = fetching, 2 = finished.
  int         m_phase = 0;
  logic [8:0] m_instr = '0;
  bit         m_valid = 0;
  bit         m_done  = 0;
  int         m_count = 0;
  logic [8:0] m_mem [16];

  typedef struct {
    bit          st;
    logic [9:0]  pc;
    bit          fl;
    logic [8:0]  ei;
    bit          ev;
    bit          ed;
    logic [15:0] ec;
  } vec_t;
  vec_t vt[$];

  task automatic addv(input bit st, input int pc, input bit fl, input int ei,
                      input bit ev, input bit ed, input int ec);
    vec_t v;
    v.st = st; v.pc = 10'(pc); v.fl = fl; v.ei = 9'(ei);
    v.ev = ev; v.ed = ed; v.ec = 16'(ec);
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_edge();
    int ph; logic [8:0] ni; bit nv, nd; int nc;
    ph = m_phase; ni = m_instr; nv = m_valid; nd = m_done; nc = m_count;
    if (Reset) begin
      ph = 0; ni = '0; nv = 0; nd = 0; nc = 0;
    end else if (bus.Start) begin
      ph = 0; nv = 0; nd = 0;
    end else if (m_phase == 0) begin
      ph = 1; nc = 0; nv = 0;
    end else if (m_phase == 1) begin
      ni = m_mem[bus.prog_ctr[3:0]];
      nv = !bus.flush;
      if (m_valid) nc = (m_count + 1 > 65535) ? 65535 : m_count + 1;
      if (m_valid && m_instr == HALT) begin
        ph = 2; nd = 1; nv = 0;
      end
    end
    if (!Reset && m_phase == 0 && bus.load_en)
      m_mem[bus.load_addr[3:0]] = bus.load_data;
    m_phase = ph; m_instr = ni; m_valid = nv; m_done = nd; m_count = nc;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " instr"}, 16'(bus.instr), 16'(m_instr));
    check({tag, " valid"}, 16'(bus.instr_valid), 16'(m_valid));
    check({tag, " done"},  16'(bus.done), 16'(m_done));
    check({tag, " count"}, bus.inst_count, 16'(m_count));
  endtask

  initial begin
    logic [8:0] prog [4];
    prog[0] = 9'h010; prog[1] = 9'h020; prog[2] = 9'h030; prog[3] = 9'h1FF;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;

    Reset = 1'b1;
    bus.Start = 1'b1; bus.prog_ctr = '0; bus.flush = 1'b0;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;

    step(); step();
    check("reset instr", 16'(bus.instr), 16'h0);
    check("reset valid", 16'(bus.instr_valid), 16'h0);
    check("reset done",  16'(bus.done), 16'h0);
    check("reset count", bus.inst_count, 16'h0);

    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.load_en = 1'b1; bus.load_addr = 10'(i); bus.load_data = prog[i];
      step();
    end
    bus.load_en = 1'b0;

    // Straight program, then a flush in DONE which must change nothing.
    addv(0,0,0, 9'h000,0,0,0);
    addv(0,0,0, 9'h010,1,0,0);
    addv(0,1,0, 9'h020,1,0,1);
    addv(0,2,0, 9'h030,1,0,2);
    addv(0,3,0, 9'h1FF,1,0,3);
    addv(0,3,0, 9'h1FF,0,1,4);
    addv(0,3,1, 9'h1FF,0,1,4);
    addv(1,0,0, 9'h1FF,0,0,4);
    // Flush on the edge capturing 020.
    addv(0,0,0, 9'h1FF,0,0,0);
    addv(0,0,0, 9'h010,1,0,0);
    addv(0,1,1, 9'h020,0,0,1);
    addv(0,2,0, 9'h030,1,0,1);
    addv(0,3,0, 9'h1FF,1,0,2);
    addv(0,3,0, 9'h1FF,0,1,3);
    addv(1,0,0, 9'h1FF,0,0,3);
    // Flush on the edge capturing the halt word: no finish.
    addv(0,0,0, 9'h1FF,0,0,0);
    addv(0,0,0, 9'h010,1,0,0);
    addv(0,1,0, 9'h020,1,0,1);
    addv(0,2,0, 9'h030,1,0,2);
    addv(0,3,1, 9'h1FF,0,0,3);
    addv(0,0,0, 9'h010,1,0,3);
    addv(0,1,0, 9'h020,1,0,4);

    for (int i = 0; i < vt.size(); i++) begin
      bus.Start = vt[i].st; bus.prog_ctr = vt[i].pc; bus.flush = vt[i].fl;
      step();
      check($sformatf("vec%0d instr", i), 16'(bus.instr), 16'(vt[i].ei));
      check($sformatf("vec%0d valid", i), 16'(bus.instr_valid), 16'(vt[i].ev));
      check($sformatf("vec%0d done", i),  16'(bus.done), 16'(vt[i].ed));
      check($sformatf("vec%0d count", i), bus.inst_count, vt[i].ec);
    end
    bus.flush = 1'b0;

    // Load attempt while running must be ignored.
    bus.load_en = 1'b1; bus.load_addr = '0; bus.load_data = 9'h0AA;
    bus.prog_ctr = 10'd1;
    step(); step();
    bus.load_en = 1'b0; bus.prog_ctr = '0;
    step();
    check("runload instr", 16'(bus.instr), 16'h010);
    bus.Start = 1'b1; step();
    bus.Start = 1'b0; step();
    step();
    check("reread instr", 16'(bus.instr), 16'h010);
    check("reread valid", 16'(bus.instr_valid), 16'h1);

    // Reset in the middle of a run, then rerun the retained program.
    bus.prog_ctr = 10'd1; step();
    Reset = 1'b1; step();
    check("midreset instr", 16'(bus.instr), 16'h0);
    check("midreset valid", 16'(bus.instr_valid), 16'h0);
    check("midreset done",  16'(bus.done), 16'h0);
    check("midreset count", bus.inst_count, 16'h0);
    Reset = 1'b0; step();
    for (int i = 0; i < 4; i++) begin
      bus.prog_ctr = 10'(i); step();
      check($sformatf("rerun instr%0d", i), 16'(bus.instr), 16'(prog[i]));
      check($sformatf("rerun valid%0d", i), 16'(bus.instr_valid), 16'h1);
    end
    step();
    check("rerun done",  16'(bus.done), 16'h1);
    check("rerun count", bus.inst_count, 16'd4);
    check("rerun valid", 16'(bus.instr_valid), 16'h0);

    // Count saturation over a long non-halting loop.
    bus.Start = 1'b1; step();
    bus.Start = 1'b0; step();
    for (int i = 0; i < 65540; i++) begin
      bus.prog_ctr = 10'(i % 3); step();
    end
    check("sat count", bus.inst_count, 16'hFFFF);
    step();
    check("sat hold", bus.inst_count, 16'hFFFF);
    check_model("sat model");

    // Random program and random control against the reference model.
    bus.Start = 1'b1; step();
    for (int i = 0; i < 16; i++) begin
      bus.load_en = 1'b1; bus.load_addr = 10'(i);
      bus.load_data = ($urandom_range(3) == 0) ? HALT : 9'($urandom);
      step();
    end
    bus.load_en = 1'b0;
    check_model("preload");
    for (int i = 0; i < 500; i++) begin
      Reset         = ($urandom_range(63) == 0);
      bus.Start     = ($urandom_range(15) == 0);
      bus.prog_ctr  = 10'($urandom_range(15));
      bus.flush     = ($urandom_range(4) == 0);
      bus.load_en   = ($urandom_range(2) == 0);
      bus.load_addr = 10'($urandom_range(15));
      bus.load_data = ($urandom_range(3) == 0) ? HALT : 9'($urandom);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_reg.md
# instr_fetch_reg

Instruction-fetch register stage sitting directly downstream of the program counter. Each running cycle it reads the instruction word addressed by `prog_ctr` from an internal, loadable instruction memory into a registered instruction output with a valid bit, squashes the word on a taken branch, detects the halt word, and raises `done`. It also counts retired instructions for per-program performance reporting.

## Interface
- `IW`, 9: instruction word width.
- `PCW`, 10: program counter width; memory depth is 2^PCW.
- `HALT_WORD`, 9'h1FF: encoding that ends the current program.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `Reset`  in  1  synchronous, active-high; highest priority.
- `Start`  in  1  high = hold/abort current program; falling to 0 starts a run.
- `prog_ctr`  in  PCW  fetch address from PC stage.
- `flush`  in  1  branch taken this cycle; squash word captured at this edge.
- `load_en`  in  1  program-load write strobe (honoured in IDLE only).
- `load_addr`  in  PCW  program-load address.
- `load_data`  in  IW  program-load data.
- `instr`  out  IW  registered instruction word.
- `instr_valid`  out  1  `instr` is a live instruction for decode.
- `done`  out  1  halt word retired; program finished.
- `inst_count`  out  16  retired-instruction count, saturating.

## Operation
- States: IDLE, RUN, DONE. Next-state priority per edge: Reset > Start > state rules.
- Reset=1: state<=IDLE; `instr`=0, `instr_valid`=0, `done`=0, `inst_count`=0. Memory contents NOT cleared.
- Start=1 in any state: state<=IDLE, `instr_valid`<=0, `done`<=0; `instr` and `inst_count` hold.
- IDLE, Start=0: state<=RUN; `inst_count`<=0; `instr_valid` stays 0 this edge.
- IDLE, load_en=1: mem[load_addr]<=load_data. load_en ignored in RUN and DONE.
- RUN, each edge: `instr`<=mem[prog_ctr]; `instr_valid`<=~flush.
- RUN, edge where `instr_valid`=1: `inst_count`<=`inst_count`+1, saturating at 16'hFFFF.
- RUN, edge where `instr_valid`=1 and `instr`==HALT_WORD: state<=DONE, `done`<=1, `instr_valid`<=0; the halt word counts as retired.
- DONE: all outputs hold; `done`=1 until Start or Reset.
- flush during IDLE/DONE: no effect.
- Halt word arriving with `instr_valid`=0 (squashed): ignored, no transition.

## Timing
- Memory read synchronous, one-cycle latency: `prog_ctr` sampled at edge k appears on `instr` after edge k.
- Start-up: Reset released with Start=0 -> edge 1 enters RUN, edge 2 first `instr_valid`=1 holding mem[prog_ctr@edge2].
- Flush: flush high at edge k -> `instr_valid`=0 for the cycle after k; next edge resumes normal capture (one-bubble penalty).
- Count update and halt detection both act on the word presented before the edge; `done` rises one edge after halt word is shown valid.
- Load-to-run: a word written at edge k is readable from edge k+1.
- Reset mid-RUN: next edge all outputs at reset values, state IDLE; next Start=0 edge re-enters RUN.
- Start pulsed mid-RUN: aborts without `done`; `inst_count` holds until re-entry to RUN clears it.

## Test plan
- Load mem[0..3]={9'h010,9'h020,9'h030,9'h1FF}, release Reset with Start=0, prog_ctr 0,1,2,3 -> `instr` 010,020,030,1FF valid on consecutive cycles, `done`=1 one edge after 1FF shown, `inst_count`=4, `instr_valid`=0.
- Same program, flush=1 on the edge capturing 9'h020 -> one cycle `instr_valid`=0, `inst_count` ends at 3.
- Flush on the edge capturing HALT_WORD -> no DONE; state stays RUN, `done`=0.
- load_en=1 during RUN to addr 0 with 9'h0AA -> mem[0] unchanged; reread after Start shows original word.
- Preload `inst_count` near saturation (65,540 non-halt words via looping prog_ctr) -> `inst_count` sticks at 16'hFFFF.
- Reset asserted mid-RUN -> next cycle `instr`=0, `instr_valid`=0, `done`=0, `inst_count`=0; memory retains loaded program and reruns identically.
